// File: rtl/atmega_io_arbiter.sv
// atmega_io_arbiter
//
// Two-master arbiter for the ATmega I/O register bus. Master 0 (CPU core) and
// master 1 (debugger / DMA) share one addr/wr/rd/data bus towards the I/O
// peripherals. Requests are serialised IDLE -> ISSUE -> DONE with round-robin
// fairness on ties, and a lock lets the current owner keep the bus across an
// atomic read-modify-write.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   m*_req/lock/addr/wr/rd/wdat  per-master request side
//   m*_ack, m*_rdat           one-cycle completion pulse and registered read data
//   bus_addr/wr/rd/dat_in     towards the slaves, driven only during ISSUE
//   bus_dat_out               combinational read data from the slaves
//   busy                      high in ISSUE and DONE
//   owner                     master granted last (or currently)
module atmega_io_arbiter #(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int DATA_WIDTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m0_req,
  input  logic                         m0_lock,
  input  logic [BUS_ADDR_DATA_LEN-1:0] m0_addr,
  input  logic                         m0_wr,
  input  logic                         m0_rd,
  input  logic [DATA_WIDTH-1:0]        m0_wdat,
  output logic                         m0_ack,
  output logic [DATA_WIDTH-1:0]        m0_rdat,
  input  logic                         m1_req,
  input  logic                         m1_lock,
  input  logic [BUS_ADDR_DATA_LEN-1:0] m1_addr,
  input  logic                         m1_wr,
  input  logic                         m1_rd,
  input  logic [DATA_WIDTH-1:0]        m1_wdat,
  output logic                         m1_ack,
  output logic [DATA_WIDTH-1:0]        m1_rdat,
  output logic [BUS_ADDR_DATA_LEN-1:0] bus_addr,
  output logic                         bus_wr,
  output logic                         bus_rd,
  output logic [DATA_WIDTH-1:0]        bus_dat_in,
  input  logic [DATA_WIDTH-1:0]        bus_dat_out,
  output logic                         busy,
  output logic                         owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic                         lock_active;
  logic [BUS_ADDR_DATA_LEN-1:0] lat_addr;
  logic                         lat_wr;
  logic                         lat_rd;
  logic [DATA_WIDTH-1:0]        lat_wdat;

  logic grant_valid;
  logic grant_sel;

  // Grant selection in IDLE. Under lock only the owner is eligible; otherwise
  // a tie goes to the master that did not win last time.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = owner;
    if (lock_active) begin
      grant_sel   = owner;
      grant_valid = owner ? m1_req : m0_req;
    end else if (m0_req && m1_req) begin
      grant_sel   = ~owner;
      grant_valid = 1'b1;
    end else if (m0_req) begin
      grant_sel   = 1'b0;
      grant_valid = 1'b1;
    end else if (m1_req) begin
      grant_sel   = 1'b1;
      grant_valid = 1'b1;
    end
  end

  // Next-state logic; ISSUE and DONE each last exactly one clock.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Transaction latch, ownership, lock tracking and registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner       <= 1'b1;
      lock_active <= 1'b0;
      lat_addr    <= '0;
      lat_wr      <= 1'b0;
      lat_rd      <= 1'b0;
      lat_wdat    <= '0;
      m0_rdat     <= '0;
      m1_rdat     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner    <= grant_sel;
            lat_addr <= grant_sel ? m1_addr : m0_addr;
            lat_wr   <= grant_sel ? m1_wr   : m0_wr;
            lat_rd   <= grant_sel ? m1_rd   : m0_rd;
            lat_wdat <= grant_sel ? m1_wdat : m0_wdat;
          end
        end
        ISSUE: begin
          // Writes and null requests return zero so a stale read never leaks.
          if (owner) m1_rdat <= bus_rd ? bus_dat_out : '0;
          else       m0_rdat <= bus_rd ? bus_dat_out : '0;
        end
        DONE: begin
          lock_active <= owner ? m1_lock : m0_lock;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are gated by ISSUE so no stale address or strobe reaches the
  // slaves; a request with both strobes set is treated as a write only.
  always_comb begin
    bus_wr     = 1'b0;
    bus_rd     = 1'b0;
    bus_addr   = '0;
    bus_dat_in = '0;
    if (state == ISSUE) begin
      bus_wr     = lat_wr;
      bus_rd     = lat_rd & ~lat_wr;
      bus_addr   = lat_addr;
      bus_dat_in = lat_wdat;
    end
  end

  assign busy   = (state != IDLE);
  assign m0_ack = (state == DONE) && !owner;
  assign m1_ack = (state == DONE) &&  owner;

endmodule

// File: tb/tb_atmega_io_arbiter.sv
// tb_atmega_io_arbiter
//
// Directed bench for atmega_io_arbiter. A small slave memory model answers
// reads combinationally and captures writes at the end of ISSUE. Inputs are
// driven and outputs sampled 1 time unit after each rising edge; a negedge
// monitor counts strobes and acks.
module tb_atmega_io_arbiter;

  logic       clk;
  logic       rst;
  logic       m0_req, m0_lock, m0_wr, m0_rd;
  logic [7:0] m0_addr, m0_wdat;
  logic       m0_ack;
  logic [7:0] m0_rdat;
  logic       m1_req, m1_lock, m1_wr, m1_rd;
  logic [7:0] m1_addr, m1_wdat;
  logic       m1_ack;
  logic [7:0] m1_rdat;
  logic [7:0] bus_addr;
  logic       bus_wr, bus_rd;
  logic [7:0] bus_dat_in, bus_dat_out;
  logic       busy, owner;

  int errors = 0;
  int checks = 0;

  int wr_cnt = 0, rd_cnt = 0, m0_ack_cnt = 0, m1_ack_cnt = 0, m1_bus_cnt = 0;

  logic [7:0] mem [256];

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] din;
    logic       busy_issue;
    logic       own_ack;
    logic       other_ack;
    logic [7:0] rdat;
  } obs_t;

  atmega_io_arbiter #(.BUS_ADDR_DATA_LEN(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wr(m0_wr),
    .m0_rd(m0_rd), .m0_wdat(m0_wdat), .m0_ack(m0_ack), .m0_rdat(m0_rdat),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wr(m1_wr),
    .m1_rd(m1_rd), .m1_wdat(m1_wdat), .m1_ack(m1_ack), .m1_rdat(m1_rdat),
    .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_dat_in(bus_dat_in), .bus_dat_out(bus_dat_out),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: combinational read data, write on the edge ending ISSUE.
  assign bus_dat_out = bus_rd ? mem[bus_addr] : 8'h00;
  always @(posedge clk) if (bus_wr) mem[bus_addr] <= bus_dat_in;

  always @(negedge clk) begin
    if (bus_wr) wr_cnt++;
    if (bus_rd) rd_cnt++;
    if (m0_ack) m0_ack_cnt++;
    if (m1_ack) m1_ack_cnt++;
    if ((bus_wr || bus_rd) && owner) m1_bus_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_req = 0; m0_lock = 0; m0_wr = 0; m0_rd = 0; m0_addr = 0; m0_wdat = 0;
    m1_req = 0; m1_lock = 0; m1_wr = 0; m1_rd = 0; m1_addr = 0; m1_wdat = 0;
  endtask

  task automatic drive(input bit m, input logic rd, input logic wr,
                       input logic [7:0] addr, input logic [7:0] wdat,
                       input logic lock);
    if (m) begin
      m1_req = 1; m1_rd = rd; m1_wr = wr; m1_addr = addr; m1_wdat = wdat; m1_lock = lock;
    end else begin
      m0_req = 1; m0_rd = rd; m0_wr = wr; m0_addr = addr; m0_wdat = wdat; m0_lock = lock;
    end
  endtask

  // One uncontended transaction: capture the ISSUE cycle and the DONE cycle.
  task automatic run_txn(input bit m, input logic rd, input logic wr,
                         input logic [7:0] addr, input logic [7:0] wdat,
                         output obs_t o);
    drive(m, rd, wr, addr, wdat, 1'b0);
    tick();
    o.wr = bus_wr; o.rd = bus_rd; o.addr = bus_addr; o.din = bus_dat_in;
    o.busy_issue = busy;
    tick();
    o.own_ack   = m ? m1_ack : m0_ack;
    o.other_ack = m ? m0_ack : m1_ack;
    o.rdat      = m ? m1_rdat : m0_rdat;
    clear_inputs();
    tick();
  endtask

  task automatic test_reset();
    rst = 0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({m0_ack, m1_ack, bus_wr, bus_rd} !== 4'b0) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {m0_ack, m1_ack, bus_wr, bus_rd}); end
    checks++; if ({bus_addr, bus_dat_in, m0_rdat, m1_rdat} !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", {bus_addr, bus_dat_in, m0_rdat, m1_rdat}); end
    checks++; if (owner !== 1'b1) begin errors++; $display("[TB] FAIL reset_owner: got %b expected 1", owner); end
    rst = 1;
  endtask

  task automatic test_single_write();
    obs_t o;
    int wr0, m1a0;
    wr0 = wr_cnt; m1a0 = m1_ack_cnt;
    run_txn(1'b0, 1'b0, 1'b1, 8'h25, 8'hA5, o);
    checks++; if ({o.wr, o.rd, o.busy_issue} !== 3'b101) begin errors++; $display("[TB] FAIL write_strobes: got %b expected 101", {o.wr, o.rd, o.busy_issue}); end
    checks++; if ({o.addr, o.din} !== 16'h25A5) begin errors++; $display("[TB] FAIL write_bus: got %h expected 25a5", {o.addr, o.din}); end
    checks++; if ({o.own_ack, o.other_ack} !== 2'b10) begin errors++; $display("[TB] FAIL write_ack: got %b expected 10", {o.own_ack, o.other_ack}); end
    checks++; if (wr_cnt - wr0 !== 1) begin errors++; $display("[TB] FAIL write_count: got %0d expected 1", wr_cnt - wr0); end
    checks++; if (m1_ack_cnt - m1a0 !== 0) begin errors++; $display("[TB] FAIL write_m1_ack: got %0d expected 0", m1_ack_cnt - m1a0); end
    checks++; if (mem[8'h25] !== 8'hA5) begin errors++; $display("[TB] FAIL write_mem: got %h expected a5", mem[8'h25]); end
  endtask

  task automatic test_read();
    obs_t o;
    int rd0;
    rd0 = rd_cnt;
    run_txn(1'b1, 1'b1, 1'b0, 8'h23, 8'h00, o);
    checks++; if ({o.wr, o.rd, o.addr} !== 10'b01_0010_0011) begin errors++; $display("[TB] FAIL read_bus: got %b expected 0100100011", {o.wr, o.rd, o.addr}); end
    checks++; if ({o.own_ack, o.other_ack} !== 2'b10) begin errors++; $display("[TB] FAIL read_ack: got %b expected 10", {o.own_ack, o.other_ack}); end
    checks++; if (o.rdat !== 8'h3C) begin errors++; $display("[TB] FAIL read_rdat: got %h expected 3c", o.rdat); end
    checks++; if (rd_cnt - rd0 !== 1) begin errors++; $display("[TB] FAIL read_count: got %0d expected 1", rd_cnt - rd0); end
    checks++; if (m1_rdat !== 8'h3C) begin errors++; $display("[TB] FAIL read_hold: got %h expected 3c", m1_rdat); end
  endtask

  task automatic test_contention();
    int n;
    int at_cycle [4];
    logic who [4];
    int exp_cycle [4] = '{2, 5, 8, 11};
    logic exp_who [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    n = 0;
    test_reset();
    drive(1'b0, 1'b0, 1'b1, 8'h10, 8'h01, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'h11, 8'h02, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if ((m0_ack || m1_ack) && n < 4) begin
        at_cycle[n] = i;
        who[n] = m1_ack;
        n++;
        if (n == 4) begin
          clear_inputs();
          break;
        end
      end
    end
    checks++; if (n !== 4) begin errors++; $display("[TB] FAIL contend_count: got %0d expected 4", n); end
    for (int k = 0; k < n; k++) begin
      checks++; if (who[k] !== exp_who[k]) begin errors++; $display("[TB] FAIL contend_order[%0d]: got M%0d expected M%0d", k, who[k], exp_who[k]); end
      checks++; if (at_cycle[k] !== exp_cycle[k]) begin errors++; $display("[TB] FAIL contend_cycle[%0d]: got %0d expected %0d", k, at_cycle[k], exp_cycle[k]); end
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_lock();
    int b0;
    b0 = m1_bus_cnt;
    drive(1'b0, 1'b1, 1'b0, 8'h23, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 8'h40, 8'h66, 1'b0);
    tick();
    checks++; if ({owner, bus_rd} !== 2'b01) begin errors++; $display("[TB] FAIL lock_first_grant: got %b expected 01", {owner, bus_rd}); end
    tick();
    checks++; if ({m0_ack, m0_rdat} !== 9'h13C) begin errors++; $display("[TB] FAIL lock_read: got %h expected 13c", {m0_ack, m0_rdat}); end
    tick();
    m0_req = 0; m0_rd = 0; m0_lock = 0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL lock_wait_idle: got %b expected 0", busy); end
    drive(1'b0, 1'b0, 1'b1, 8'h23, 8'h55, 1'b0);
    tick();
    checks++; if ({owner, bus_wr, bus_addr} !== 10'b01_0010_0011) begin errors++; $display("[TB] FAIL lock_write_grant: got %b expected 0100100011", {owner, bus_wr, bus_addr}); end
    tick();
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("[TB] FAIL lock_write_ack: got %b expected 1", m0_ack); end
    checks++; if (m1_bus_cnt - b0 !== 0) begin errors++; $display("[TB] FAIL lock_m1_blocked: got %0d expected 0", m1_bus_cnt - b0); end
    m0_req = 0; m0_wr = 0;
    tick(); tick();
    checks++; if ({owner, bus_wr, bus_addr, bus_dat_in} !== 18'b11_0100_0000_0110_0110) begin errors++; $display("[TB] FAIL lock_m1_served: got %h expected 34066", {owner, bus_wr, bus_addr, bus_dat_in}); end
    tick();
    checks++; if (m1_ack !== 1'b1) begin errors++; $display("[TB] FAIL lock_m1_ack: got %b expected 1", m1_ack); end
    clear_inputs();
    tick();
    checks++; if (mem[8'h23] !== 8'h55) begin errors++; $display("[TB] FAIL lock_mem: got %h expected 55", mem[8'h23]); end
  endtask

  task automatic test_null_and_both();
    obs_t o;
    run_txn(1'b0, 1'b1, 1'b0, 8'h23, 8'h00, o);
    checks++; if (o.rdat !== 8'h55) begin errors++; $display("[TB] FAIL null_pre_read: got %h expected 55", o.rdat); end
    run_txn(1'b0, 1'b0, 1'b0, 8'h30, 8'h12, o);
    checks++; if ({o.wr, o.rd, o.busy_issue, o.own_ack} !== 4'b0011) begin errors++; $display("[TB] FAIL null_strobes: got %b expected 0011", {o.wr, o.rd, o.busy_issue, o.own_ack}); end
    checks++; if (o.rdat !== 8'h00) begin errors++; $display("[TB] FAIL null_rdat: got %h expected 00", o.rdat); end
    run_txn(1'b1, 1'b1, 1'b0, 8'h23, 8'h00, o);
    checks++; if (o.rdat !== 8'h55) begin errors++; $display("[TB] FAIL both_pre_read: got %h expected 55", o.rdat); end
    run_txn(1'b1, 1'b1, 1'b1, 8'h31, 8'h77, o);
    checks++; if ({o.wr, o.rd, o.own_ack} !== 3'b101) begin errors++; $display("[TB] FAIL both_strobes: got %b expected 101", {o.wr, o.rd, o.own_ack}); end
    checks++; if (o.rdat !== 8'h00) begin errors++; $display("[TB] FAIL both_rdat: got %h expected 00", o.rdat); end
    checks++; if (mem[8'h31] !== 8'h77) begin errors++; $display("[TB] FAIL both_mem: got %h expected 77", mem[8'h31]); end
  endtask

  task automatic test_reset_in_issue();
    int a0, a1;
    drive(1'b0, 1'b0, 1'b1, 8'h50, 8'h99, 1'b0);
    tick();
    checks++; if (bus_wr !== 1'b1) begin errors++; $display("[TB] FAIL rst_issue_pre: got %b expected 1", bus_wr); end
    #1 rst = 0;
    #1;
    checks++; if ({busy, bus_wr, bus_rd, bus_addr, bus_dat_in} !== 19'h0) begin errors++; $display("[TB] FAIL rst_issue_outputs: got %h expected 0", {busy, bus_wr, bus_rd, bus_addr, bus_dat_in}); end
    checks++; if (owner !== 1'b1) begin errors++; $display("[TB] FAIL rst_issue_owner: got %b expected 1", owner); end
    a0 = m0_ack_cnt; a1 = m1_ack_cnt;
    tick(); tick();
    checks++; if ((m0_ack_cnt - a0) + (m1_ack_cnt - a1) !== 0) begin errors++; $display("[TB] FAIL rst_issue_no_ack: got %0d expected 0", (m0_ack_cnt - a0) + (m1_ack_cnt - a1)); end
    checks++; if (mem[8'h50] !== 8'h00) begin errors++; $display("[TB] FAIL rst_issue_no_write: got %h expected 00", mem[8'h50]); end
    rst = 1;
    clear_inputs();
    drive(1'b0, 1'b1, 1'b0, 8'h23, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h31, 8'h00, 1'b0);
    tick();
    checks++; if ({owner, busy, bus_rd, bus_addr} !== 11'b011_0010_0011) begin errors++; $display("[TB] FAIL rst_first_grant: got %b expected 01100100011", {owner, busy, bus_rd, bus_addr}); end
    tick();
    checks++; if ({m0_ack, m1_ack, m0_rdat} !== 10'b10_0101_0101) begin errors++; $display("[TB] FAIL rst_first_ack: got %b expected 1001010101", {m0_ack, m1_ack, m0_rdat}); end
    clear_inputs();
    tick(); tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h23] = 8'h3C;
    clear_inputs();
    rst = 0;
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_lock();
    test_null_and_both();
    test_reset_in_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
